// File: rtl/dlx_ctrl_fsm.sv
// Multi-cycle DLX control automaton: sequences IF/ID/EX/MEM/WB, handshakes with ROM/RAM,
// drives datapath strobes, guards memory waits with a watchdog and counts retired instructions.
module dlx_ctrl_fsm #(
  parameter int TIMEOUT = 255,
  parameter int RET_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_data_valid,
  input  logic             d_data_valid,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             dec_wb,
  output logic             IF,
  output logic             ID,
  output logic             EX,
  output logic             MEM,
  output logic             WB,
  output logic             i_req,
  output logic             ir_load,
  output logic             d_req,
  output logic             d_write_enable,
  output logic             rf_write_enable,
  output logic             pc_update,
  output logic             error,
  output logic [RET_W-1:0] retired_count
);

  typedef enum logic [2:0] {
    S_RST, S_IF, S_ID, S_EX, S_MEM, S_WB, S_ERR
  } state_t;

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit WDOG_EN = (TIMEOUT > 0);

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic              r_load;
  logic              r_store;
  logic              r_wb;
  logic [RET_W-1:0]  r_retired;
  logic              w_timeout;
  logic              w_waiting;

  // Timeout fires on the last permitted wait cycle, so a valid arriving then still wins.
  assign w_timeout = WDOG_EN && (r_wait == WAIT_LAST);
  assign w_waiting = (r_state == S_IF) || (r_state == S_MEM);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST: w_next = S_IF;
      S_IF: begin
        if (i_data_valid)   w_next = S_ID;
        else if (w_timeout) w_next = S_ERR;
      end
      S_ID: w_next = (dec_load && dec_store) ? S_ERR : S_EX;
      S_EX: begin
        if (r_load || r_store) w_next = S_MEM;
        else if (r_wb)         w_next = S_WB;
        else                   w_next = S_IF;
      end
      S_MEM: begin
        if (d_data_valid)   w_next = r_load ? S_WB : S_IF;
        else if (w_timeout) w_next = S_ERR;
      end
      S_WB:    w_next = S_IF;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_ERR;
    endcase
  end

  always_comb begin
    IF              = (r_state == S_IF);
    ID              = (r_state == S_ID);
    EX              = (r_state == S_EX);
    MEM             = (r_state == S_MEM);
    WB              = (r_state == S_WB);
    error           = (r_state == S_ERR);
    i_req           = IF;
    ir_load         = IF && i_data_valid;
    d_req           = MEM;
    d_write_enable  = MEM && r_store;
    rf_write_enable = WB;
    pc_update       = (EX && !r_load && !r_store && !r_wb) ||
                      (MEM && d_data_valid && r_store) ||
                      WB;
    retired_count   = r_retired;
  end

  // Op class latch, wait counter (restarts whenever a wait state is entered) and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_load    <= 1'b0;
      r_store   <= 1'b0;
      r_wb      <= 1'b0;
      r_wait    <= '0;
      r_retired <= '0;
    end else begin
      if (r_state == S_ID) begin
        r_load  <= dec_load;
        r_store <= dec_store;
        r_wb    <= dec_wb;
      end
      if (WDOG_EN && w_waiting && (w_next == r_state)) begin
        r_wait <= r_wait + 1'b1;
      end else begin
        r_wait <= '0;
      end
      if (pc_update) begin
        r_retired <= r_retired + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dlx_ctrl_fsm.sv
// Bench for dlx_ctrl_fsm: three parameterisations, each driven by per-instruction phase
// sequences generated from the control rules and compared cycle by cycle.
module tb_dlx_ctrl_fsm;

  localparam int P_RST = 0, P_IF = 1, P_ID = 2, P_EX = 3, P_MEM = 4, P_WB = 5, P_ERR = 6;

  typedef struct {
    int ph;
    bit v;
    bit ld;
    bit st;
    bit wb;
  } cyc_t;

  logic        clk;
  logic        rst_v [3];
  logic        iv_v  [3];
  logic        dv_v  [3];
  logic        ld_v  [3];
  logic        st_v  [3];
  logic        wb_v  [3];
  logic [11:0] obs   [3];
  logic [31:0] cnt_o [3];

  int          nvec;
  int          nerr;
  int unsigned mcnt [3];
  cyc_t        q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int GT = (g == 0) ? 4 : ((g == 1) ? 255 : 0);
    localparam int GR = (g == 0) ? 4 : ((g == 1) ? 32 : 8);
    logic          w_if, w_id, w_ex, w_mem, w_wb, w_ireq, w_irl, w_dreq, w_dwe, w_rfwe, w_pc, w_err;
    logic [GR-1:0] w_cnt;
    dlx_ctrl_fsm #(.TIMEOUT(GT), .RET_W(GR)) dut (
      .clk             (clk),
      .reset           (rst_v[g]),
      .i_data_valid    (iv_v[g]),
      .d_data_valid    (dv_v[g]),
      .dec_load        (ld_v[g]),
      .dec_store       (st_v[g]),
      .dec_wb          (wb_v[g]),
      .IF              (w_if),
      .ID              (w_id),
      .EX              (w_ex),
      .MEM             (w_mem),
      .WB              (w_wb),
      .i_req           (w_ireq),
      .ir_load         (w_irl),
      .d_req           (w_dreq),
      .d_write_enable  (w_dwe),
      .rf_write_enable (w_rfwe),
      .pc_update       (w_pc),
      .error           (w_err),
      .retired_count   (w_cnt)
    );
    assign obs[g]   = {w_if, w_id, w_ex, w_mem, w_wb, w_ireq, w_irl, w_dreq, w_dwe, w_rfwe, w_pc, w_err};
    assign cnt_o[g] = 32'(w_cnt);
  end

  function automatic int to_of(int k);
    return (k == 0) ? 4 : ((k == 1) ? 255 : 0);
  endfunction

  function automatic logic [31:0] mask_of(int k);
    int w;
    logic [63:0] m;
    w = (k == 0) ? 4 : ((k == 1) ? 32 : 8);
    m = (64'd1 << w) - 64'd1;
    return m[31:0];
  endfunction

  function automatic cyc_t mk(int ph, bit v, bit ld, bit st, bit wb);
    cyc_t c;
    c.ph = ph; c.v = v; c.ld = ld; c.st = st; c.wb = wb;
    return c;
  endfunction

  function automatic bit retires(cyc_t e);
    return (e.ph == P_EX && !e.ld && !e.st && !e.wb) ||
           (e.ph == P_MEM && e.v && e.st) ||
           (e.ph == P_WB);
  endfunction

  function automatic logic [11:0] expv(cyc_t e, logic iv);
    bit f, d, x, m, w;
    f = (e.ph == P_IF); d = (e.ph == P_ID); x = (e.ph == P_EX);
    m = (e.ph == P_MEM); w = (e.ph == P_WB);
    return {f, d, x, m, w, f, f & iv, m, m & e.st, w, retires(e), e.ph == P_ERR};
  endfunction

  // A handshake wait of w idle cycles; returns 1 when the watchdog would trip first.
  function automatic bit push_wait(int ph, int w, int to, bit ld, bit st, bit wb);
    if (to != 0 && w >= to) begin
      repeat (to) q.push_back(mk(ph, 1'b0, ld, st, wb));
      q.push_back(mk(P_ERR, 1'b0, ld, st, wb));
      return 1'b1;
    end
    repeat (w) q.push_back(mk(ph, 1'b0, ld, st, wb));
    q.push_back(mk(ph, 1'b1, ld, st, wb));
    return 1'b0;
  endfunction

  function automatic bit build(int k, bit ld, bit st, bit wb, int iw, int dw);
    bit err;
    q.delete();
    err = push_wait(P_IF, iw, to_of(k), ld, st, wb);
    if (!err) begin
      q.push_back(mk(P_ID, 1'b0, ld, st, wb));
      if (ld && st) begin
        q.push_back(mk(P_ERR, 1'b0, ld, st, wb));
        err = 1'b1;
      end else begin
        q.push_back(mk(P_EX, 1'b0, ld, st, wb));
        if (ld || st) err = push_wait(P_MEM, dw, to_of(k), ld, st, wb);
        if (!err && (ld || (!st && wb))) q.push_back(mk(P_WB, 1'b0, ld, st, wb));
      end
    end
    if (err) repeat (3) q.push_back(mk(P_ERR, 1'b0, ld, st, wb));
    return err;
  endfunction

  task automatic check(int k, string tag, logic [11:0] e_out, logic [31:0] e_cnt);
    nvec++;
    assert (obs[k] === e_out)
      else begin
        nerr++;
        $error("FAIL %s outputs got %b want %b", tag, obs[k], e_out);
      end
    nvec++;
    assert (cnt_o[k] === e_cnt)
      else begin
        nerr++;
        $error("FAIL %s retired_count got %0d want %0d", tag, cnt_o[k], e_cnt);
      end
  endtask

  task automatic rand_in(int k);
    iv_v[k] = 1'($urandom_range(0, 1));
    dv_v[k] = 1'($urandom_range(0, 1));
    ld_v[k] = 1'($urandom_range(0, 1));
    st_v[k] = 1'($urandom_range(0, 1));
    wb_v[k] = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset(int k);
    @(negedge clk);
    rst_v[k] = 1'b1;
    rand_in(k);
    mcnt[k] = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rand_in(k);
      #1;
      check(k, $sformatf("inst%0d reset_hold%0d", k, i), 12'b0, 32'd0);
    end
    @(negedge clk);
    rst_v[k] = 1'b0;
    rand_in(k);
    #1;
    check(k, $sformatf("inst%0d reset_release", k), 12'b0, 32'd0);
  endtask

  task automatic play(int k, int limit);
    cyc_t e;
    for (int j = 0; j < q.size() && (limit < 0 || j < limit); j++) begin
      e = q[j];
      @(negedge clk);
      rand_in(k);
      if (e.ph == P_IF)  iv_v[k] = e.v;
      if (e.ph == P_MEM) dv_v[k] = e.v;
      if (e.ph == P_ID) begin
        ld_v[k] = e.ld; st_v[k] = e.st; wb_v[k] = e.wb;
      end
      #1;
      check(k, $sformatf("inst%0d cyc%0d ph%0d", k, j, e.ph), expv(e, iv_v[k]), mcnt[k] & mask_of(k));
      if (retires(e)) mcnt[k]++;
    end
  endtask

  task automatic run(int k, bit ld, bit st, bit wb, int iw, int dw, int limit);
    bit err;
    err = build(k, ld, st, wb, iw, dw);
    play(k, limit);
    if (err || limit >= 0) do_reset(k);
  endtask

  task automatic run_rand(int k, int n, int maxw);
    int c;
    for (int i = 0; i < n; i++) begin
      c = $urandom_range(0, 3);
      run(k, c == 2, c == 3, (c == 1) || (c >= 2 && $urandom_range(0, 1) == 1),
          $urandom_range(0, maxw), $urandom_range(0, maxw), -1);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    for (int k = 0; k < 3; k++) begin
      rst_v[k] = 1'b1; iv_v[k] = 1'b0; dv_v[k] = 1'b0;
      ld_v[k] = 1'b0; st_v[k] = 1'b0; wb_v[k] = 1'b0;
      mcnt[k] = 0;
    end

    // Default parameters: directed phases, random mix, illegal class, reset mid-store.
    do_reset(1);
    run(1, 0, 0, 1, 0, 0, -1);
    run(1, 1, 0, 1, 0, 5, -1);
    run(1, 0, 1, 0, 2, 0, -1);
    run(1, 0, 0, 0, 0, 0, -1);
    run_rand(1, 40, 3);
    run(1, 0, 0, 0, 0, 0, -1);
    run(1, 1, 1, 0, 1, 0, -1);
    run(1, 0, 1, 0, 0, 10, 5);
    run(1, 0, 0, 1, 0, 0, -1);
    @(negedge clk);
    rst_v[1] = 1'b1;

    // TIMEOUT=4, RET_W=4: watchdog edges and counter wrap.
    do_reset(0);
    run(0, 0, 0, 1, 0, 0, -1);
    run(0, 0, 1, 0, 0, 3, -1);
    run(0, 0, 1, 1, 3, 0, -1);
    run(0, 0, 1, 0, 0, 100, -1);
    for (int i = 0; i < 17; i++) run(0, 0, 0, 0, 0, 0, -1);
    run(0, 0, 0, 0, 0, 0, -1);
    run(0, 0, 0, 1, 4, 0, -1);
    run_rand(0, 30, 5);
    @(negedge clk);
    rst_v[0] = 1'b1;

    // TIMEOUT=0: long stalls never fault.
    do_reset(2);
    run(2, 1, 0, 0, 300, 300, -1);
    run(2, 0, 0, 1, 0, 0, -1);
    run(2, 0, 1, 0, 0, 0, -1);
    @(negedge clk);
    rst_v[2] = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
